lcd_hex_line_formatter: RTL and testbench
=========================================

LCD_HEX_LINE_FORMATTER -- requirements
Module: lcd_hex_line_formatter

Interface
REQ-001 The block SHALL have parameter PARAM_PAD_CHAR, default 8'h20, meaning the ASCII fill character for columns 13-15.
REQ-002 The block SHALL have parameter PARAM_BLANK_LZ, default 1'b0, meaning that 1 replaces leading zero hex digits with PARAM_PAD_CHAR.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset; both are listed below.
REQ-004 i_clk_40mhz  in  1  sole clock; all state changes on its rising edge.
REQ-005 i_rst_40mhz_n  in  1  asynchronous, active-low reset.
REQ-006 i_start  in  1  one-cycle request to format one 16-character line.
REQ-007 i_label  in  32  four ASCII label characters; [31:24] is column 0.
REQ-008 i_value  in  32  value rendered as eight hex digits, MSB first.
REQ-009 o_char_valid  out  1  the character on o_char_data is offered.
REQ-010 o_char_data  out  8  ASCII character.
REQ-011 o_char_idx  out  4  LCD column 0-15 of o_char_data.
REQ-012 i_char_ready  in  1  downstream LCD feed FSM accepts the character.
REQ-013 o_busy  out  1  a line is in progress.
REQ-014 o_done  out  1  one-cycle pulse after column 15 is accepted.

Function
REQ-015 The FSM SHALL have states IDLE, LOAD, EMIT and DONE.
REQ-016 In IDLE, i_start=1 SHALL register i_label and i_value into internal copies and move to LOAD.
REQ-017 In any state other than IDLE, i_start SHALL be ignored, and the registered copies SHALL NOT change.
REQ-018 LOAD SHALL set the column counter to 0 and the leading-zero flag to 1, then move to EMIT; o_char_valid SHALL rise 2 cycles after the i_start cycle.
REQ-019 In EMIT, o_char_valid SHALL be 1, and a transfer SHALL occur on any cycle with o_char_valid=1 and i_char_ready=1.
REQ-020 While o_char_valid=1 and i_char_ready=0, o_char_data and o_char_idx SHALL stay stable.
REQ-021 Each transfer SHALL advance the column counter by 1; the next character SHALL be offered on the following cycle with no bubble.
REQ-022 Columns 0-3 SHALL carry label bytes [31:24], [23:16], [15:8] and [7:0].
REQ-023 Column 4 SHALL carry 8'h3A (':').
REQ-024 Columns 5-12 SHALL carry value nibbles [31:28] down to [3:0].
REQ-025 Columns 13-15 SHALL carry PARAM_PAD_CHAR.
REQ-026 Hex conversion SHALL map nibble n to 8'h30+n for n<10 and to 8'h37+n for n>=10, giving uppercase A-F.
REQ-027 If PARAM_BLANK_LZ=1, a zero nibble seen while the leading-zero flag is 1 SHALL emit PARAM_PAD_CHAR.
REQ-028 The first nonzero nibble SHALL clear the leading-zero flag.
REQ-029 Column 12 SHALL always emit a digit, so an all-zero value renders as "0" in column 12.
REQ-030 The registered-copy nibble select SHALL be an 8-bit shift or mux; column arithmetic is 4-bit and SHALL NOT wrap past 15 within a line.
REQ-031 A transfer at column 15 SHALL move the FSM to DONE.
REQ-032 DONE SHALL assert o_done for exactly 1 cycle with o_char_valid=0, then return to IDLE.
REQ-033 An i_start in the DONE cycle SHALL be ignored.
REQ-034 o_busy SHALL be 1 in LOAD, EMIT and DONE, and 0 in IDLE.
REQ-035 i_char_ready while o_char_valid=0 SHALL have no effect.

Reset
REQ-036 Reset assertion SHALL asynchronously force IDLE, o_char_valid=0, o_char_data=8'h00, o_char_idx=0, o_busy=0 and o_done=0, and clear the registered copies and counter.
REQ-037 Reset asserted mid-line SHALL abort the line with no o_done; the next i_start after release SHALL start again from column 0.
REQ-038 Outputs SHALL be registered, with no combinational path from i_char_ready to o_char_valid.

Verification
REQ-039 Ready-always check: i_label="ADDR", i_value=32'h00AB12CF, i_char_ready=1 -> 16 consecutive transfers "ADDR:00AB12CF   ", o_done 1 cycle after column 15, 18 cycles from i_start to o_done.
REQ-040 Backpressure check: same stimulus, i_char_ready toggles 1/0 with 3-cycle stalls at columns 4 and 15 -> identical character stream, data and idx stable during stalls.
REQ-041 Leading-zero check: PARAM_BLANK_LZ=1, i_value=32'h0000_0000 -> columns 5-11 are 8'h20 and column 12 is 8'h30; i_value=32'h000F_0000 -> columns 5-7 are blank, columns 8-12 are "F0000".
REQ-042 Start-while-busy check: i_start with i_value=32'h11111111 at column 7 of a 32'hFFFFFFFF line -> the stream stays "FFFFFFFF" and no second line follows.
REQ-043 Mid-line reset check: reset asserted at column 9 -> all outputs 0 immediately; after release, i_start gives column 0 again and exactly 16 transfers.
REQ-044 Exhaustive nibble check: i_value=32'h01234567 then 32'h89ABCDEF -> digits match the REQ-026 mapping for all 16 nibble values.

Source files
------------

// File: rtl/lcd_hex_line_formatter_if.sv
// ---------------------------------------------------------------------------
// lcd_hex_line_formatter_if
// Character stream between the line formatter and the downstream LCD feed.
//   o_char_valid  formatter -> LCD  a character is offered
//   o_char_data   formatter -> LCD  ASCII character
//   o_char_idx    formatter -> LCD  LCD column 0-15 of o_char_data
//   i_char_ready  LCD -> formatter  the character is accepted this cycle
// master = formatter side, slave = LCD feed side.
// ---------------------------------------------------------------------------
interface lcd_hex_line_formatter_if;
   logic       o_char_valid;
   logic [7:0] o_char_data;
   logic [3:0] o_char_idx;
   logic       i_char_ready;

   modport master (
      output o_char_valid,
      output o_char_data,
      output o_char_idx,
      input  i_char_ready
   );

   modport slave (
      input  o_char_valid,
      input  o_char_data,
      input  o_char_idx,
      output i_char_ready
   );
endinterface

// File: rtl/lcd_hex_line_formatter.sv
// ---------------------------------------------------------------------------
// lcd_hex_line_formatter
// Formats one 16-column LCD line "LLLL:HHHHHHHH" followed by three pad
// characters and streams it one character per transfer.
// Ports:
//   i_clk_40mhz    sole clock, rising edge
//   i_rst_40mhz_n  asynchronous active-low reset
//   i_start        one-cycle line request (accepted only when idle)
//   i_label        four ASCII label characters, [31:24] is column 0
//   i_value        value rendered as eight uppercase hex digits, MSB first
//   o_busy         a line is in progress
//   o_done         one-cycle pulse after column 15 is accepted
//   lcd            character stream (valid/data/idx out, ready in)
// All outputs are registered; i_char_ready only affects next-cycle state.
// ---------------------------------------------------------------------------
module lcd_hex_line_formatter #(
   parameter logic [7:0] PARAM_PAD_CHAR = 8'h20,
   parameter logic       PARAM_BLANK_LZ = 1'b0
) (
   input  logic                            i_clk_40mhz,
   input  logic                            i_rst_40mhz_n,
   input  logic                            i_start,
   input  logic [31:0]                     i_label,
   input  logic [31:0]                     i_value,
   output logic                            o_busy,
   output logic                            o_done,
   lcd_hex_line_formatter_if.master        lcd
);

   typedef enum logic [1:0] {IDLE, LOAD, EMIT, DONE} state_t;

   state_t      state_q, state_d;
   logic [31:0] label_q, value_q;
   logic        lz_q, lz_d;
   logic        load_copy;
   logic [7:0]  data_d;
   logic [3:0]  idx_d;

   // Character generator inputs/outputs for the column about to be offered.
   logic [3:0]  col_sel;
   logic        lz_in, lz_calc, is_digit;
   logic [3:0]  nib;
   logic [7:0]  char_calc;

   function automatic logic [7:0] hex_ascii(input logic [3:0] n);
      return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
   endfunction

   // LOAD presents column 0 with a fresh leading-zero flag; EMIT presents
   // the column after the one being transferred.
   always_comb begin
      col_sel   = (state_q == LOAD) ? 4'd0 : lcd.o_char_idx + 4'd1;
      lz_in     = (state_q == LOAD) ? 1'b1 : lz_q;
      is_digit  = (col_sel >= 4'd5) && (col_sel <= 4'd12);

      case (col_sel)
         4'd5:    nib = value_q[31:28];
         4'd6:    nib = value_q[27:24];
         4'd7:    nib = value_q[23:20];
         4'd8:    nib = value_q[19:16];
         4'd9:    nib = value_q[15:12];
         4'd10:   nib = value_q[11:8];
         4'd11:   nib = value_q[7:4];
         4'd12:   nib = value_q[3:0];
         default: nib = 4'h0;
      endcase

      lz_calc = lz_in;
      case (col_sel)
         4'd0:    char_calc = label_q[31:24];
         4'd1:    char_calc = label_q[23:16];
         4'd2:    char_calc = label_q[15:8];
         4'd3:    char_calc = label_q[7:0];
         4'd4:    char_calc = 8'h3A;
         default: char_calc = PARAM_PAD_CHAR;
      endcase

      if (is_digit) begin
         if (nib != 4'h0) lz_calc = 1'b0;
         // Column 12 is always a digit so an all-zero value still shows "0".
         if (PARAM_BLANK_LZ && lz_in && (nib == 4'h0) && (col_sel != 4'd12))
            char_calc = PARAM_PAD_CHAR;
         else
            char_calc = hex_ascii(nib);
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      // NOTE: every signal gets a default first so no path can infer a latch.
      state_d   = state_q;
      load_copy = 1'b0;
      data_d    = lcd.o_char_data;
      idx_d     = lcd.o_char_idx;
      lz_d      = lz_q;

      case (state_q)
         IDLE: begin
            if (i_start) begin
               state_d   = LOAD;
               load_copy = 1'b1;
            end
         end
         LOAD: begin
            state_d = EMIT;
            data_d  = char_calc;
            idx_d   = 4'd0;
            lz_d    = lz_calc;
         end
         EMIT: begin
            // o_char_valid is 1 throughout EMIT, so ready alone means transfer.
            if (lcd.i_char_ready) begin
               if (lcd.o_char_idx == 4'd15) begin
                  state_d = DONE;
               end else begin
                  data_d = char_calc;
                  idx_d  = col_sel;
                  lz_d   = lz_calc;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk_40mhz or negedge i_rst_40mhz_n) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      if (!i_rst_40mhz_n) state_q <= IDLE;
      else                state_q <= state_d;
   end

   always_ff @(posedge i_clk_40mhz or negedge i_rst_40mhz_n) begin
      if (!i_rst_40mhz_n) begin
         // NOTE: the registered copies are plain data registers, but they are
         // reset anyway so a line can never render stale values after reset.
         label_q          <= 32'h0;
         value_q          <= 32'h0;
         lz_q             <= 1'b0;
         lcd.o_char_valid <= 1'b0;
         lcd.o_char_data  <= 8'h00;
         lcd.o_char_idx   <= 4'd0;
         o_busy           <= 1'b0;
         o_done           <= 1'b0;
      end else begin
         if (load_copy) begin
            label_q <= i_label;
            value_q <= i_value;
         end
         lz_q             <= lz_d;
         lcd.o_char_data  <= data_d;
         lcd.o_char_idx   <= idx_d;
         lcd.o_char_valid <= (state_d == EMIT);
         o_busy           <= (state_d != IDLE);
         o_done           <= (state_d == DONE);
      end
   end

endmodule

// File: tb/tb_lcd_hex_line_formatter.sv
// ---------------------------------------------------------------------------
// tb_lcd_hex_line_formatter
// Two instances share all stimulus: dut (leading zeros shown) and dut_lz
// (leading zeros blanked). Each line is compared against hand-written
// expected 16-character strings.
// ---------------------------------------------------------------------------
module tb_lcd_hex_line_formatter;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [31:0] label;
   logic [31:0] value;
   logic        ready;
   logic        busy, done, busy_lz, done_lz;

   int checks = 0;
   int errors = 0;

   lcd_hex_line_formatter_if lcd ();
   lcd_hex_line_formatter_if lcd_lz ();

   assign lcd.i_char_ready    = ready;
   assign lcd_lz.i_char_ready = ready;

   lcd_hex_line_formatter #(.PARAM_PAD_CHAR(8'h20), .PARAM_BLANK_LZ(1'b0)) dut (
      .i_clk_40mhz   (clk),
      .i_rst_40mhz_n (rst_n),
      .i_start       (start),
      .i_label       (label),
      .i_value       (value),
      .o_busy        (busy),
      .o_done        (done),
      .lcd           (lcd)
   );

   lcd_hex_line_formatter #(.PARAM_PAD_CHAR(8'h20), .PARAM_BLANK_LZ(1'b1)) dut_lz (
      .i_clk_40mhz   (clk),
      .i_rst_40mhz_n (rst_n),
      .i_start       (start),
      .i_label       (label),
      .i_value       (value),
      .o_busy        (busy_lz),
      .o_done        (done_lz),
      .lcd           (lcd_lz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string what, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", what, act, exp);
      end
   endtask

   // mode 0: ready always 1, exact latency checked.
   // mode 1: ready toggles, with 3-cycle stalls at columns 4 and 15.
   // inject_col >= 0: pulse i_start (value 11111111) at that column and in
   // the DONE cycle; neither may disturb the line or start another one.
   task automatic run_line(input string name, input logic [31:0] lab, input logic [31:0] val,
                           input logic [127:0] exp0, input logic [127:0] exp1,
                           input int mode, input int inject_col);
      int   n = 0;
      int   first_k = -1;
      int   done_k = -1;
      int   st4 = 0, st15 = 0;
      logic tog = 1'b0;
      logic prev_stall = 1'b0;
      logic [7:0] prev_d = 8'h00;
      logic [3:0] prev_i = 4'd0;
      logic injected = 1'b0;
      logic inj_active = 1'b0;
      logic busy_ok = 1'b1;

      @(negedge clk);
      label = lab;
      value = val;
      start = 1'b1;
      ready = (mode == 0);
      @(posedge clk);
      #1 start = 1'b0;

      for (int k = 1; k <= 80 && done_k < 0; k++) begin
         @(negedge clk);
         if (inj_active) begin
            start = 1'b0;
            inj_active = 1'b0;
         end
         if (k == 1) check($sformatf("%s busy in LOAD", name), {31'h0, busy}, 32'd1);
         if (prev_stall) begin
            check($sformatf("%s stall data stable", name), {24'h0, lcd.o_char_data}, {24'h0, prev_d});
            check($sformatf("%s stall idx stable", name), {28'h0, lcd.o_char_idx}, {28'h0, prev_i});
         end
         if (mode == 0) begin
            ready = 1'b1;
         end else begin
            tog   = ~tog;
            ready = tog;
            if (lcd.o_char_valid && lcd.o_char_idx == 4'd4 && st4 < 3) begin
               ready = 1'b0;
               st4++;
            end
            if (lcd.o_char_valid && lcd.o_char_idx == 4'd15 && st15 < 3) begin
               ready = 1'b0;
               st15++;
            end
         end
         if (lcd.o_char_valid) begin
            if (first_k < 0) first_k = k;
            if (ready) begin
               if (n < 16) begin
                  check($sformatf("%s col%0d data", name, n), {24'h0, lcd.o_char_data},
                        {24'h0, exp0[127-8*n -: 8]});
                  check($sformatf("%s col%0d lz data", name, n), {24'h0, lcd_lz.o_char_data},
                        {24'h0, exp1[127-8*n -: 8]});
                  check($sformatf("%s col%0d idx", name, n), {28'h0, lcd.o_char_idx}, n);
               end else begin
                  check($sformatf("%s extra transfer", name), n, 32'd15);
               end
               n++;
            end
            prev_stall = !ready;
            prev_d     = lcd.o_char_data;
            prev_i     = lcd.o_char_idx;
         end else begin
            prev_stall = 1'b0;
         end
         if (inject_col >= 0 && !injected && lcd.o_char_valid && lcd.o_char_idx == inject_col[3:0]) begin
            start      = 1'b1;
            label      = "XXXX";
            value      = 32'h11111111;
            injected   = 1'b1;
            inj_active = 1'b1;
         end
         if (done) begin
            done_k = k;
            check($sformatf("%s valid low in DONE", name), {31'h0, lcd.o_char_valid}, 32'd0);
            if (inject_col >= 0) begin
               start      = 1'b1;
               inj_active = 1'b1;
            end
         end
      end

      check($sformatf("%s done seen", name), {31'h0, done_k > 0}, 32'd1);
      check($sformatf("%s transfer count", name), n, 32'd16);
      if (mode == 0) begin
         check($sformatf("%s first valid cycle", name), first_k, 32'd2);
         check($sformatf("%s start to done cycles", name), done_k, 32'd18);
      end

      @(negedge clk);
      start = 1'b0;
      check($sformatf("%s done one cycle", name), {31'h0, done}, 32'd0);
      check($sformatf("%s idle after done", name), {31'h0, busy}, 32'd0);
      if (inject_col >= 0) begin
         for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (busy || lcd.o_char_valid) busy_ok = 1'b0;
         end
         check($sformatf("%s no second line", name), {31'h0, busy_ok}, 32'd1);
      end
      ready = 1'b0;
   endtask

   typedef struct packed {
      logic [31:0]  label;
      logic [31:0]  value;
      logic [127:0] exp0;
      logic [127:0] exp1;
   } vec_t;

   vec_t vecs[7];

   initial begin
      logic idle_ok;
      logic found;
      logic quiet_ok;

      vecs[0] = '{"ADDR", 32'h00AB12CF, "ADDR:00AB12CF   ", "ADDR:  AB12CF   "};
      vecs[1] = '{"ZERO", 32'h00000000, "ZERO:00000000   ", "ZERO:       0   "};
      vecs[2] = '{"LZF ", 32'h000F0000, "LZF :000F0000   ", "LZF :   F0000   "};
      vecs[3] = '{"NIB0", 32'h01234567, "NIB0:01234567   ", "NIB0: 1234567   "};
      vecs[4] = '{"NIB1", 32'h89ABCDEF, "NIB1:89ABCDEF   ", "NIB1:89ABCDEF   "};
      vecs[5] = '{"ONE ", 32'h00000001, "ONE :00000001   ", "ONE :       1   "};
      vecs[6] = '{"HI  ", 32'h10000000, "HI  :10000000   ", "HI  :10000000   "};

      rst_n = 1'b0;
      start = 1'b0;
      label = 32'h0;
      value = 32'h0;
      ready = 1'b0;
      #23;
      check("reset valid", {31'h0, lcd.o_char_valid}, 32'd0);
      check("reset data", {24'h0, lcd.o_char_data}, 32'h0);
      check("reset idx", {28'h0, lcd.o_char_idx}, 32'h0);
      check("reset busy", {31'h0, busy}, 32'd0);
      check("reset done", {31'h0, done}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Ready while nothing is offered must not start anything.
      ready   = 1'b1;
      idle_ok = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (lcd.o_char_valid || busy || done) idle_ok = 1'b0;
      end
      check("ready while idle ignored", {31'h0, idle_ok}, 32'd1);
      ready = 1'b0;

      for (int i = 0; i < 7; i++)
         run_line($sformatf("vec%0d", i), vecs[i].label, vecs[i].value, vecs[i].exp0, vecs[i].exp1, 0, -1);

      run_line("backpressure", "ADDR", 32'h00AB12CF, "ADDR:00AB12CF   ", "ADDR:  AB12CF   ", 1, -1);
      run_line("start_busy", "FFFF", 32'hFFFFFFFF, "FFFF:FFFFFFFF   ", "FFFF:FFFFFFFF   ", 0, 7);

      // Reset in the middle of a line.
      @(negedge clk);
      label = "RST9";
      value = 32'h12345678;
      start = 1'b1;
      ready = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 40 && !found; k++) begin
         @(negedge clk);
         if (lcd.o_char_valid && lcd.o_char_idx == 4'd9) found = 1'b1;
      end
      check("rst column 9 reached", {31'h0, found}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("rst valid", {31'h0, lcd.o_char_valid}, 32'd0);
      check("rst data", {24'h0, lcd.o_char_data}, 32'h0);
      check("rst idx", {28'h0, lcd.o_char_idx}, 32'h0);
      check("rst busy", {31'h0, busy}, 32'd0);
      check("rst done", {31'h0, done}, 32'd0);
      check("rst lz busy", {31'h0, busy_lz}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n    = 1'b1;
      quiet_ok = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (done || busy || lcd.o_char_valid) quiet_ok = 1'b0;
      end
      check("rst aborts line without done", {31'h0, quiet_ok}, 32'd1);
      run_line("after_rst", "RST9", 32'h12345678, "RST9:12345678   ", "RST9:12345678   ", 0, -1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
